// File: rtl/uc_pkg.sv
// Shared definitions for the uc micro-sequencer: opcode fields, ALU operation
// codes, skip condition codes, FSM state encoding and the decoded control bundle.
package uc_pkg;

    // FSM states of the sequencer
    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        SKIP  = 2'b10,
        HALT  = 2'b11
    } state_t;

    // ALU operation codes
    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;

    // Opcode field prefixes
    localparam logic [1:0] OP_LI_PFX   = 2'b00;       // 00xxxx
    localparam logic [1:0] OP_ALU_PFX  = 2'b01;       // 01ooox
    localparam logic [5:0] OP_JUMP     = 6'b100000;   // 100000
    localparam logic [3:0] OP_SKIP_PFX = 4'b1001;     // 1001cc
    localparam logic [2:0] OP_NOP_PFX  = 3'b101;      // 101xxx

    // Skip condition codes (Opcode[1:0] of a skip)
    localparam logic [1:0] CC_EQ = 2'b00;
    localparam logic [1:0] CC_NE = 2'b01;
    localparam logic [1:0] CC_GT = 2'b10;
    localparam logic [1:0] CC_LT = 2'b11;

    // Control bundle produced by the decoder for the EXEC cycle
    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we;
        logic [2:0] alu_op;
        logic       is_skip;
        logic       reserved;
    } ctrl_t;

    // Evaluate a skip condition from the ALU flags (carry = borrow on subtract)
    function automatic logic skip_cond(input logic [1:0] cc, input logic zero, input logic carry);
        logic res;
        case (cc)
            CC_EQ:   res = zero;
            CC_NE:   res = !zero;
            CC_GT:   res = !zero && !carry;
            default: res = carry;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode decoder for uc. Reserved opcodes decode to nop controls
// with the reserved flag raised; the top decides whether that flag traps.
module uc_decode
    import uc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       carry,
    output ctrl_t      ctrl,
    output logic       cond
);

    // Map the opcode onto the control bundle
    always_comb begin
        // NOTE: every output gets a default before the decode so no path leaves it unassigned (no latch).
        ctrl          = '0;
        ctrl.s_inc    = 1'b1;
        ctrl.alu_op   = ALU_PASS;
        if (opcode[5:4] == OP_LI_PFX) begin
            ctrl.s_inm = 1'b1;
            ctrl.we    = 1'b1;
        end else if (opcode[5:4] == OP_ALU_PFX) begin
            ctrl.alu_op = opcode[3:1];
            ctrl.we     = 1'b1;
        end else if (opcode == OP_JUMP) begin
            ctrl.s_inc = 1'b0;
        end else if (opcode[5:2] == OP_SKIP_PFX) begin
            ctrl.is_skip = 1'b1;
            ctrl.alu_op  = ALU_SUB;
        end else if (opcode[5:3] == OP_NOP_PFX) begin
            ctrl.s_inc = 1'b1;
        end else begin
            ctrl.reserved = 1'b1;
        end
    end

    // Skip condition from the low opcode bits and the current ALU flags
    always_comb begin
        cond = skip_cond(opcode[1:0], zero, carry);
    end

endmodule

// File: rtl/uc.sv
// uc: multi-cycle control unit. FETCH loads the instruction register, EXEC
// drives decoded controls, SKIP applies a captured skip condition to the PC.
// Optional build macro UC_ILLEGAL_TRAP_EN: reserved opcodes halt the unit
// until reset; without it they execute as nop and halted is tied low.
module uc
    import uc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             zero,
    input  logic             carry,
    output logic             ir_we,
    output logic             pc_we,
    output logic             s_inc,
    output logic             s_skip,
    output logic             s_inm,
    output logic             we,
    output logic [2:0]       ALUOp,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t state_q;
    state_t state_d;
    logic   cond_q;
    ctrl_t  ctrl;
    logic   cond;
    logic   trap;
    logic   retire;

    uc_decode u_decode (
        .opcode (Opcode),
        .zero   (zero),
        .carry  (carry),
        .ctrl   (ctrl),
        .cond   (cond)
    );

`ifdef UC_ILLEGAL_TRAP_EN
    assign trap   = ctrl.reserved;
    assign halted = (state_q == HALT);
`else
    // Reserved opcodes run as nop here, so the flag is intentionally unused.
    logic unused_reserved;
    assign unused_reserved = ctrl.reserved;
    assign trap   = 1'b0;
    assign halted = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = EXEC;
            EXEC: begin
                if (trap)              state_d = HALT;
                else if (ctrl.is_skip) state_d = SKIP;
                else                   state_d = FETCH;
            end
            SKIP:    state_d = FETCH;
            default: state_d = HALT;
        endcase
    end

    // Capture the skip condition at the end of a skip's EXEC cycle; flags are ignored otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                  cond_q <= 1'b0;
        else if (state_q == EXEC && ctrl.is_skip)    cond_q <= cond;
    end

    // An instruction retires when EXEC returns to FETCH or when SKIP completes
    assign retire = (state_q == EXEC && state_d == FETCH) || (state_q == SKIP);

    // Retired-instruction counter, wraps naturally at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      retired <= '0;
        else if (retire) retired <= retired + CNT_W'(1);
    end

    // Output decode per state
    always_comb begin
        ir_we  = 1'b0;
        pc_we  = 1'b0;
        s_inc  = 1'b1;
        s_skip = 1'b0;
        s_inm  = 1'b0;
        we     = 1'b0;
        ALUOp  = ALU_PASS;
        case (state_q)
            // reset is low only while held in reset; ir_we stays off until release
            FETCH: ir_we = reset;
            EXEC: begin
                if (trap) begin
                    pc_we = 1'b0;
                end else if (ctrl.is_skip) begin
                    ALUOp = ctrl.alu_op;
                end else begin
                    pc_we = 1'b1;
                    s_inc = ctrl.s_inc;
                    s_inm = ctrl.s_inm;
                    we    = ctrl.we;
                    ALUOp = ctrl.alu_op;
                end
            end
            SKIP: begin
                pc_we  = 1'b1;
                s_skip = cond_q;
            end
            default: begin
                pc_we = 1'b0;
            end
        endcase
    end

endmodule
